// File: rtl/tcam_access_arbiter_pkg.sv
// Shared constants and FSM encoding for the TCAM access arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tcam_access_arbiter_pkg;

    localparam int DEF_KEY_W   = 128;
    localparam int DEF_ENTRIES = 16;
    localparam int DEF_IDX_W   = $clog2(DEF_ENTRIES);
    localparam int DEF_NREQ    = 2;
    localparam int DEF_LKP_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/tcam_access_arbiter_if.sv
// Bundles the config-write, lookup request/response and TCAM-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready handshake on lookups; responses and TCAM side are not backpressured.
// Modports: slave = arbiter view, master = environment (MMIO, requesters, TCAM array).
interface tcam_access_arbiter_if
    import tcam_access_arbiter_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W,
    parameter int IDX_W = DEF_IDX_W,
    parameter int NREQ  = DEF_NREQ
);
    logic                  cfg_wr_en;
    logic [IDX_W-1:0]      cfg_wr_addr;
    logic                  cfg_wr_is_mask;
    logic [KEY_W-1:0]      cfg_wr_data;
    logic                  cfg_wr_busy;
    logic                  cfg_ovr;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*KEY_W-1:0] req_key;
    logic [NREQ-1:0]       rsp_valid;
    logic                  rsp_hit;
    logic [IDX_W-1:0]      rsp_idx;
    logic                  tcam_wr_en;
    logic [IDX_W-1:0]      tcam_wr_addr;
    logic                  tcam_wr_is_mask;
    logic [KEY_W-1:0]      tcam_wr_data;
    logic                  tcam_lkp_en;
    logic [KEY_W-1:0]      tcam_lkp_key;
    logic                  tcam_hit;
    logic [IDX_W-1:0]      tcam_idx;

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_is_mask, cfg_wr_data,
        input  req_valid, req_key, tcam_hit, tcam_idx,
        output cfg_wr_busy, cfg_ovr, req_ready, rsp_valid, rsp_hit, rsp_idx,
        output tcam_wr_en, tcam_wr_addr, tcam_wr_is_mask, tcam_wr_data,
        output tcam_lkp_en, tcam_lkp_key
    );

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_is_mask, cfg_wr_data,
        output req_valid, req_key, tcam_hit, tcam_idx,
        input  cfg_wr_busy, cfg_ovr, req_ready, rsp_valid, rsp_hit, rsp_idx,
        input  tcam_wr_en, tcam_wr_addr, tcam_wr_is_mask, tcam_wr_data,
        input  tcam_lkp_en, tcam_lkp_key
    );

endinterface

// File: rtl/tcam_access_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after rr_ptr (wrapping) wins.
// Latency: combinational.
// Backpressure: none; caller decides whether the grant is used.
// Ports: req (request vector), rr_ptr (search start), gnt (one-hot), gnt_idx (binary), gnt_vld (any grant).
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            gnt_vld
);
    logic [ID_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + i) % NREQ);
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcam_access_arbiter.sv
// Owns the TCAM port pair: round-robin lookups from NREQ requesters, config writes as drain barriers.
// Latency: grant at T -> tcam_lkp_en at T+1 -> rsp_valid at T+1+LKP_LAT; write = drain + 1 cycle.
// Backpressure: req_ready withheld while a write drains/issues; 1-deep write buffer, overflow drops and flags cfg_ovr.
// Ports: clk, resetn (sync, active-low), bus (tcam_access_arbiter_if.slave: cfg_*, req_*, rsp_*, tcam_*).
module tcam_access_arbiter
    import tcam_access_arbiter_pkg::*;
#(
    parameter int KEY_W   = DEF_KEY_W,
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int NREQ    = DEF_NREQ,
    parameter int LKP_LAT = DEF_LKP_LAT
) (
    input  logic                 clk,
    input  logic                 resetn,
    tcam_access_arbiter_if.slave bus
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NSTG = LKP_LAT + 1;

    state_t           state;
    logic             buf_full;
    logic [IDX_W-1:0] buf_addr;
    logic             buf_is_mask;
    logic [KEY_W-1:0] buf_data;
    logic             lkp_owed;
    logic [ID_W-1:0]  rr_ptr;
    logic [NSTG-1:0]  pipe_vld;
    logic [ID_W-1:0]  pipe_id [NSTG];
    logic [KEY_W-1:0] lkp_key_q;
    logic             wr_en_q;
    logic [IDX_W-1:0] wr_addr_q;
    logic             wr_is_mask_q;
    logic [KEY_W-1:0] wr_data_q;
    logic             ovr_q;

    logic [NREQ-1:0]  arb_gnt;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_vld;
    logic [KEY_W-1:0] sel_key;
    logic             grant_en;
    logic             xfer;
    logic             pipe_empty;
    logic             buf_free;
    logic             buf_take;
    logic             rsp_fire;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        sel_key = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) sel_key = bus.req_key[i*KEY_W +: KEY_W];
        end
    end

    // A pending write blocks grants unless a post-write lookup is still owed.
    assign grant_en   = resetn && (state == IDLE) && !(buf_full && !lkp_owed);
    assign xfer       = grant_en && arb_vld;
    assign pipe_empty = ~|pipe_vld;
    // The WRITE cycle consumes the buffer, so a same-cycle request can refill it.
    assign buf_free   = (state == WRITE);
    assign buf_take   = bus.cfg_wr_en && (!buf_full || buf_free);
    assign rsp_fire   = resetn && pipe_vld[NSTG-1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            buf_full     <= 1'b0;
            buf_addr     <= '0;
            buf_is_mask  <= 1'b0;
            buf_data     <= '0;
            lkp_owed     <= 1'b0;
            rr_ptr       <= '0;
            pipe_vld     <= '0;
            for (int k = 0; k < NSTG; k++) pipe_id[k] <= '0;
            lkp_key_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_is_mask_q <= 1'b0;
            wr_data_q    <= '0;
            ovr_q        <= 1'b0;
        end else begin
            pipe_vld   <= {pipe_vld[NSTG-2:0], xfer};
            pipe_id[0] <= arb_idx;
            for (int k = 1; k < NSTG; k++) pipe_id[k] <= pipe_id[k-1];

            if (xfer) begin
                lkp_key_q <= sel_key;
                rr_ptr    <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
                lkp_owed  <= 1'b0;
            end

            if (bus.cfg_wr_en && !buf_take) ovr_q <= 1'b1;

            if (buf_take) begin
                buf_full    <= 1'b1;
                buf_addr    <= bus.cfg_wr_addr;
                buf_is_mask <= bus.cfg_wr_is_mask;
                buf_data    <= bus.cfg_wr_data;
            end else if (buf_free) begin
                buf_full <= 1'b0;
            end

            wr_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (buf_full && !lkp_owed) state <= DRAIN;
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state        <= WRITE;
                        wr_en_q      <= 1'b1;
                        wr_addr_q    <= buf_addr;
                        wr_is_mask_q <= buf_is_mask;
                        wr_data_q    <= buf_data;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    // Lets one waiting lookup through before a queued write drains again.
                    lkp_owed <= |bus.req_valid;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready       = grant_en ? arb_gnt : '0;
    assign bus.rsp_valid       = rsp_fire ? (NREQ'(1) << pipe_id[NSTG-1]) : '0;
    assign bus.rsp_hit         = rsp_fire && bus.tcam_hit;
    assign bus.rsp_idx         = rsp_fire ? bus.tcam_idx : '0;
    assign bus.tcam_lkp_en     = pipe_vld[0];
    assign bus.tcam_lkp_key    = lkp_key_q;
    assign bus.tcam_wr_en      = wr_en_q;
    assign bus.tcam_wr_addr    = wr_addr_q;
    assign bus.tcam_wr_is_mask = wr_is_mask_q;
    assign bus.tcam_wr_data    = wr_data_q;
    assign bus.cfg_wr_busy     = buf_full;
    assign bus.cfg_ovr         = ovr_q;

endmodule
